// File: rtl/xor_stream_arbiter.sv
// rtl/xor_stream_arbiter.sv - two-requester round-robin arbiter sharing one XOR-with-key datapath
module xor_stream_arbiter #(
   parameter int               WIDTH     = 8,
   parameter int               BURST     = 4,
   parameter logic [WIDTH-1:0] KEY_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   input  logic             key_wr,
   input  logic [WIDTH-1:0] key_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic [3:0]       out_seq,
   input  logic             out_ready,
   output logic             busy
);

   localparam int            CW      = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, new_cnt;
   logic             rr, rr_nxt;
   logic             gnt, sel_valid, other_valid, can_accept, accept, same_run;
   logic [WIDTH-1:0] key;
   logic [3:0]       seq;

   assign can_accept  = !out_valid | out_ready;
   assign sel_valid   = gnt ? req1_valid : req0_valid;
   assign other_valid = gnt ? req0_valid : req1_valid;
   assign accept      = sel_valid & can_accept & !rst;
   assign req0_ready  = !gnt & req0_valid & can_accept & !rst;
   assign req1_ready  =  gnt & req1_valid & can_accept & !rst;
   assign busy        = (state != IDLE) | out_valid;

   always_comb begin
      gnt = 1'b0;
      case (state)
         IDLE:    gnt = (req0_valid & req1_valid) ? rr : req1_valid;
         SERVE0:  gnt = !req0_valid;
         SERVE1:  gnt = req1_valid;
         default: gnt = 1'b0;
      endcase
   end

   // A grant to a requester other than the one being served starts a fresh run.
   assign same_run = (state == SERVE0 && !gnt) || (state == SERVE1 && gnt);
   assign new_cnt  = (same_run ? cnt : '0) + CNT_ONE;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rr_nxt    = rr;
      if (accept) begin
         if (new_cnt == BURST_C) begin
            cnt_nxt = '0;
            rr_nxt  = !gnt;
            if (other_valid)
               state_nxt = gnt ? SERVE0 : SERVE1;
            else
               state_nxt = gnt ? SERVE1 : SERVE0;
         end else begin
            cnt_nxt   = new_cnt;
            state_nxt = gnt ? SERVE1 : SERVE0;
         end
      end else if (state != IDLE && !req0_valid && !req1_valid) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         rr_nxt    = (state == SERVE0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rr    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rr    <= rr_nxt;
      end
   end

   // The accept path reads key before this edge's key_wr lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         out_seq   <= '0;
         seq       <= '0;
         key       <= KEY_RESET;
      end else begin
         if (key_wr)
            key <= key_in;
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= (gnt ? req1_data : req0_data) ^ key;
            out_src   <= gnt;
            out_seq   <= seq;
            seq       <= seq + 4'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xor_stream_arbiter.sv
// tb/tb_xor_stream_arbiter.sv - directed self-checking bench for xor_stream_arbiter
module tb_xor_stream_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_ready, req1_ready;
   logic       key_wr = 1'b0;
   logic [7:0] key_in = '0;
   logic       out_valid, out_src, out_ready = 1'b0, busy;
   logic [7:0] out_data;
   logic [3:0] out_seq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xor_stream_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .key_wr(key_wr), .key_in(key_in),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_seq(out_seq), .out_ready(out_ready), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data  = '0;   req1_data  = '0;
      key_wr     = 1'b0; key_in     = '0;
      out_ready  = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset with inputs toggling
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_data = 8'hC3; req1_data = 8'h3C;
         key_wr = 1'b1; key_in = 8'hFF;
         out_ready = i[0];
         #1;
         check_eq("rst_rdy0", req0_ready, 0);
         check_eq("rst_rdy1", req1_ready, 0);
         tick();
      end
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_src", out_src, 0);
      check_eq("rst_seq", out_seq, 0);
      check_eq("rst_busy", busy, 0);
      idle_inputs();
      rst = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h00; out_ready = 1'b1;
      tick();
      check_eq("keyrb_valid", out_valid, 1);
      check_eq("keyrb_data", out_data, 8'h00);
      check_eq("keyrb_busy", busy, 1);

      // Single stream under key 0x5A
      do_reset();
      key_wr = 1'b1; key_in = 8'h5A;
      tick();
      key_wr = 1'b0;
      out_ready = 1'b1;
      req0_valid = 1'b1;
      begin
         logic [7:0] din [3] = '{8'h00, 8'hFF, 8'hA5};
         logic [7:0] dexp[3] = '{8'h5A, 8'hA5, 8'hFF};
         for (int i = 0; i < 3; i++) begin
            req0_data = din[i];
            #1;
            check_eq("ss_ready", req0_ready, 1);
            tick();
            check_eq("ss_data", out_data, dexp[i]);
            check_eq("ss_src", out_src, 0);
            check_eq("ss_seq", out_seq, i);
         end
      end

      // Round robin, both continuously valid from reset
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h10;
      req1_valid = 1'b1; req1_data = 8'h20;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("rr_src", out_src, (i >> 2) & 1);
         check_eq("rr_data", out_data, ((i >> 2) & 1) ? 8'h20 : 8'h10);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      check_eq("rr_drain", out_valid, 0);
      req1_valid = 1'b1; req1_data = 8'h77;
      #1;
      check_eq("rr_solo_rdy1", req1_ready, 1);
      check_eq("rr_solo_rdy0", req0_ready, 0);
      tick();
      check_eq("rr_solo_src", out_src, 1);
      check_eq("rr_solo_data", out_data, 8'h77);

      // Backpressure
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h11; out_ready = 1'b0;
      tick();
      check_eq("bp_first", out_data, 8'h11);
      req0_data = 8'h22;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq("bp_rdy", req0_ready, 0);
         tick();
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_hold", out_data, 8'h11);
         check_eq("bp_seq", out_seq, 0);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_rdy", req0_ready, 1);
      tick();
      check_eq("bp_refill_valid", out_valid, 1);
      check_eq("bp_refill_data", out_data, 8'h22);
      check_eq("bp_refill_seq", out_seq, 1);

      // Key write colliding with an accept
      do_reset();
      key_wr = 1'b1; key_in = 8'h01;
      tick();
      key_in = 8'h0F;
      req0_valid = 1'b1; req0_data = 8'h30; out_ready = 1'b1;
      tick();
      check_eq("key_old", out_data, 8'h31);
      key_wr = 1'b0;
      tick();
      check_eq("key_new", out_data, 8'h3F);

      // Sequence wrap, then reset with a held result
      do_reset();
      req0_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         req0_data = 8'(i);
         tick();
         check_eq("wrap_seq", out_seq, i & 15);
         check_eq("wrap_data", out_data, i);
      end
      rst = 1'b1;
      tick();
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);
      rst = 1'b0;
      req0_data = 8'h44;
      tick();
      check_eq("midrst_seq", out_seq, 0);
      check_eq("midrst_data", out_data, 8'h44);
      check_eq("midrst_v", out_valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xor_stream_arbiter.md
# xor_stream_arbiter

Shares the single byte-wide XOR datapath (operand XOR key) between two valid/ready requesters. Arbitration is round-robin with a bounded burst. The key register is configured at runtime. Results leave through a one-entry registered output stage with valid/ready backpressure. The block sits between the pin-level input buses and the output bus of the top-level design wrapper.

## Interface
Parameters:
- WIDTH, 8, operand/key/result width
- BURST, 4, max consecutive accepts granted to one requester while the other waits (≥1)
- KEY_RESET, 8'h00, key value after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operand
- req0_data  in  WIDTH  requester 0 operand
- req0_ready  out  1  requester 0 operand accepted this cycle when high with req0_valid
- req1_valid / req1_data / req1_ready  same as requester 0, for requester 1
- key_wr  in  1  load key_in into key register
- key_in  in  WIDTH  new key
- out_valid  out  1  result held in output register
- out_data  out  WIDTH  operand XOR key
- out_src  out  1  requester index of the held result
- out_seq  out  4  accept sequence number of held result, wraps mod 16
- out_ready  in  1  consumer takes result when high with out_valid
- busy  out  1  FSM not in IDLE or out_valid high

## Operation
- can_accept = !out_valid | out_ready. reqN_ready = gnt==N & reqN_valid & can_accept & !rst. Accept = any reqN_valid & reqN_ready. At most one ready high per cycle.
- FSM states: IDLE, SERVE0, SERVE1. Beat counter cnt, range 0..BURST-1. Round-robin pointer rr names the requester preferred on a tie. rr = 0 after reset.
- Grant (combinational):
  - IDLE: both valid → gnt=rr; one valid → gnt=that one.
  - SERVEx: gnt=x if reqx_valid, else gnt=other.
- State update on accept from requester g:
  - cnt increments.
  - If cnt reaches BURST and the other requester is valid, or g differs from the current SERVE, then state=SERVE(other-of-g when cnt saturated, else g) with cnt cleared appropriately. When the burst limit is reached, rr = !g.
  - When the burst limit is reached with no other requester valid, remain in SERVEg with cnt=0.
- No accept while in SERVEx, with neither requester valid → IDLE, cnt=0, rr = !x.
- Output register on accept:
  - out_data = reqg_data ^ key
  - out_src = g
  - out_seq = seq, then seq+1 (mod 16)
  - out_valid = 1
- Output register on out_valid & out_ready without accept: out_valid = 0. The data, src and seq fields hold their values.
- Key register: key_wr loads key_in at the edge. An accept in the same cycle as key_wr uses the old key. Accepts from the next cycle on use the new key.
- Reset values:
  - out_valid=0, out_data=0, out_src=0, out_seq=0
  - seq=0, key=KEY_RESET, state=IDLE, cnt=0, rr=0
  - busy=0
  - req0_ready=0 and req1_ready=0 while rst is high
- Reset mid-operation discards the held result, even if out_ready is high in that cycle. A requester whose ready was low during reset must retry.

## Timing
- Latency: operand accepted at edge k → out_valid=1 with its result at edge k (visible cycle k+1).
- Throughput: 1 result/cycle while out_ready stays high. A simultaneous drain and accept refills the output register with no bubble.
- Backpressure: out_valid=1 & out_ready=0 forces both readys low. out_data, out_src and out_seq stay stable until the consumer takes the result.
- Fairness: with both requesters continuously valid and out_ready=1, accepts alternate in blocks of BURST. Either requester waits at most BURST cycles.
- The requester valids, data, key_wr/key_in and out_ready sample on the same edge. No combinational path exists from reqN_data to any output.

## Test plan
- Reset: hold rst 2 cycles with all inputs toggling → all outputs 0, key reads back as KEY_RESET through a subsequent XOR of 0x00.
- Single stream: key_wr 0x5A, then req0 sends 0x00, 0xFF, 0xA5 with out_ready=1 → out_data 0x5A, 0xA5, 0xFF on consecutive cycles, out_src=0, out_seq 0, 1, 2.
- Round robin: BURST=4, both valid continuously from reset → out_src sequence 0,0,0,0,1,1,1,1,0,… Each requester has a run of 4 before switching. A single valid on req1 alone in IDLE is granted immediately.
- Backpressure: out_ready=0 for 5 cycles after first result → out_valid stays 1 with data unchanged and req readys low. Raising out_ready drains the result and accepts the next operand in the same cycle.
- Key update collision: key_wr 0x0F in the same cycle as accepting 0x30 under key 0x01 → result 0x31. The next operand 0x30 → 0x3F.
- Wrap and mid-op reset: 17 accepts → out_seq wraps 15→0. Asserting rst while out_valid=1 → out_valid=0 next cycle, and the next result carries out_seq=0.
